serial_alu: RTL and testbench



---
 rtl/serial_alu_pkg.sv | 5 +
 rtl/serial_alu_digit_slice.sv | 22 ++
 rtl/serial_alu.sv | 94 +++++++++
 tb/tb_serial_alu.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_alu_pkg.sv
// serial_alu_pkg: shared opcode and FSM state types for the digit-serial ALU
package serial_alu_pkg;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_XOR = 2'b11} op_t;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_DONE = 2'b10} state_t;
endpackage

// File: rtl/serial_alu_digit_slice.sv
// digit_slice: combinational DIGIT-bit add/sub/and/xor slice with carry chain
module digit_slice
  import serial_alu_pkg::*;
#(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             cin,
  input  op_t              op,
  output logic [DIGIT-1:0] r_d,
  output logic             cout
);
  logic [DIGIT-1:0] bx;
  logic [DIGIT:0]   s;
  always_comb begin
    bx   = op == OP_SUB ? ~b_d : b_d;
    s    = {1'b0, a_d} + {1'b0, bx} + (DIGIT+1)'(cin);
    r_d  = op == OP_AND ? a_d & b_d : op == OP_XOR ? a_d ^ b_d : s[DIGIT-1:0];
    cout = (op == OP_ADD || op == OP_SUB) && s[DIGIT];
  end
endmodule

// File: rtl/serial_alu.sv
// serial_alu: digit-serial ALU, LSB digit first, valid/ready on both sides
module serial_alu
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  if (DIGIT < 1 || DIGIT > WIDTH || WIDTH % DIGIT != 0) begin : g_chk
    $error("serial_alu: WIDTH must be a multiple of DIGIT");
  end
  state_t           state, state_nx;
  op_t              op_q;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh, r_nx;
  logic [DIGIT-1:0] r_d;
  logic [CW-1:0]    cnt;
  logic             cy, cout, last, arith, bm;
  digit_slice #(.DIGIT(DIGIT)) u_slice (
    .a_d  (a_sh[DIGIT-1:0]),
    .b_d  (b_sh[DIGIT-1:0]),
    .cin  (cy),
    .op   (op_q),
    .r_d  (r_d),
    .cout (cout)
  );
  assign in_ready = state == S_IDLE;
  assign last     = cnt == CW'(N - 1);
  assign r_nx     = WIDTH'({r_d, r_sh} >> DIGIT);
  assign arith    = op_q == OP_ADD || op_q == OP_SUB;
  assign bm       = op_q == OP_SUB ? ~b_sh[DIGIT-1] : b_sh[DIGIT-1];
  always_comb begin
    state_nx = state;
    if (state == S_IDLE && in_valid) state_nx = S_RUN;
    if (state == S_RUN && last) state_nx = S_DONE;
    if (state == S_DONE && out_ready) state_nx = S_IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh      <= '0;
      b_sh      <= '0;
      r_sh      <= '0;
      op_q      <= OP_ADD;
      cy        <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (state == S_IDLE && in_valid) begin
        a_sh <= a;
        b_sh <= b;
        op_q <= op_t'(op);
        cy   <= op == OP_SUB;
        cnt  <= '0;
      end
      if (state == S_RUN) begin
        a_sh <= a_sh >> DIGIT;
        b_sh <= b_sh >> DIGIT;
        r_sh <= r_nx;
        cy   <= cout;
        cnt  <= cnt + 1'b1;
      end
      // a_sh/b_sh low digit holds the operand MSBs while the last digit is processed
      if (state == S_RUN && last) begin
        result    <= r_nx;
        carry     <= cout;
        zero      <= r_nx == '0;
        overflow  <= arith && (a_sh[DIGIT-1] == bm) && (r_d[DIGIT-1] != a_sh[DIGIT-1]);
        out_valid <= 1'b1;
      end
      if (state == S_DONE && out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_serial_alu.sv
// tb_serial_alu: table-driven scoreboard bench over DIGIT=2, 1 and 8 instances
module tb_serial_alu;
  typedef struct {
    int         d;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [7:0] r;
    logic       c;
    logic       z;
    logic       v;
  } vec_t;
  typedef struct {
    logic [7:0] r;
    logic       c;
    logic       z;
    logic       v;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst;
  logic       ivld[3], irdy[3], ovld[3], ordy[3], cy[3], zr[3], vf[3];
  logic [7:0] a[3], b[3], res[3];
  logic [1:0] op[3];
  int         n_cmp = 0, n_bad = 0;
  exp_t       q[$];
  vec_t       tbl[13];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    serial_alu #(.WIDTH(8), .DIGIT(g == 0 ? 2 : (g == 1 ? 1 : 8))) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (ivld[g]),
      .in_ready  (irdy[g]),
      .a         (a[g]),
      .b         (b[g]),
      .op        (op[g]),
      .out_valid (ovld[g]),
      .out_ready (ordy[g]),
      .result    (res[g]),
      .carry     (cy[g]),
      .zero      (zr[g]),
      .overflow  (vf[g])
    );
  end
  function automatic int nd(int d);
    return d == 0 ? 4 : (d == 1 ? 8 : 1);
  endfunction
  function automatic exp_t model(logic [7:0] x, logic [7:0] y, logic [1:0] o);
    exp_t       e;
    logic [8:0] s;
    s   = o == 2'b01 ? {1'b0, x} + {1'b0, ~y} + 9'd1 : {1'b0, x} + {1'b0, y};
    e.r = o == 2'b10 ? x & y : o == 2'b11 ? x ^ y : s[7:0];
    e.c = o[1] ? 1'b0 : s[8];
    e.z = e.r == 8'h00;
    e.v = o == 2'b00 ? (x[7] == y[7]) && (e.r[7] != x[7]) :
          o == 2'b01 ? (x[7] != y[7]) && (e.r[7] != x[7]) : 1'b0;
    return e;
  endfunction
  task automatic check(string n, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic launch(int d, logic [7:0] x, logic [7:0] y, logic [1:0] o);
    int t = 0;
    ivld[d] = 1'b1;
    a[d] = x;
    b[d] = y;
    op[d] = o;
    while (!irdy[d] && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!irdy[d]) check("ready_timeout", 32'(irdy[d]), 1);
    @(posedge clk); #1;
    ivld[d] = 1'b0;
    a[d] = 8'($urandom);
    b[d] = 8'($urandom);
    op[d] = 2'($urandom);
  endtask
  task automatic collect(int d);
    int   lat = 0;
    exp_t e;
    while (!ovld[d] && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, nd(d));
    if (q.size() == 0) begin
      check("queue_empty", 0, 1);
    end else begin
      e = q.pop_front();
      check("result", res[d], e.r);
      check("carry", cy[d], e.c);
      check("zero", zr[d], e.z);
      check("overflow", vf[d], e.v);
    end
  endtask
  task automatic run_exp(int d, logic [7:0] x, logic [7:0] y, logic [1:0] o, exp_t e);
    q.push_back(e);
    launch(d, x, y, o);
    collect(d);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [7:0] sr;
    logic       sc, sz, sv;
    int         acc[2], n_acc, seen;
    for (int i = 0; i < 3; i++) begin
      ivld[i] = 1'b0;
      ordy[i] = 1'b1;
      a[i] = '0;
      b[i] = '0;
      op[i] = '0;
    end
    tbl[0]  = '{0, 8'hFF, 8'h01, 2'b00, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{0, 8'h80, 8'h01, 2'b01, 8'h7F, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{0, 8'h05, 8'h07, 2'b01, 8'hFE, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{0, 8'hA5, 8'h0F, 2'b10, 8'h05, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{0, 8'hA5, 8'hA5, 2'b11, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1, 8'hFF, 8'h01, 2'b00, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1, 8'h80, 8'h01, 2'b01, 8'h7F, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1, 8'h05, 8'h07, 2'b01, 8'hFE, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{2, 8'hFF, 8'h01, 2'b00, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{2, 8'h80, 8'h01, 2'b01, 8'h7F, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{2, 8'h05, 8'h07, 2'b01, 8'hFE, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{0, 8'h7F, 8'h01, 2'b00, 8'h80, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{2, 8'hFF, 8'h0F, 2'b11, 8'hF0, 1'b0, 1'b0, 1'b0};
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_out_valid", ovld[i], 0);
      check("rst_in_ready", irdy[i], 1);
      check("rst_result", {res[i], cy[i], zr[i], vf[i]}, 0);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    foreach (tbl[i]) run_exp(tbl[i].d, tbl[i].a, tbl[i].b, tbl[i].op,
                             '{tbl[i].r, tbl[i].c, tbl[i].z, tbl[i].v});
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 4; k++) begin
        logic [7:0] x, y;
        logic [1:0] o;
        x = 8'($urandom);
        y = 8'($urandom);
        o = 2'($urandom_range(0, 3));
        run_exp(d, x, y, o, model(x, y, o));
      end
    ordy[0] = 1'b0;
    run_exp(0, 8'h3C, 8'h55, 2'b00, model(8'h3C, 8'h55, 2'b00));
    sr = res[0];
    sc = cy[0];
    sz = zr[0];
    sv = vf[0];
    ivld[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      a[0] = 8'($urandom);
      b[0] = 8'($urandom);
      @(posedge clk); #1;
      check("hold_out_valid", ovld[0], 1);
      check("hold_in_ready", irdy[0], 0);
      check("hold_result", {res[0], cy[0], zr[0], vf[0]}, {sr, sc, sz, sv});
    end
    ordy[0] = 1'b1;
    run_exp(0, 8'h12, 8'h34, 2'b01, model(8'h12, 8'h34, 2'b01));
    run_exp(0, 8'h05, 8'h07, 2'b01, model(8'h05, 8'h07, 2'b01));
    launch(0, 8'h11, 8'h22, 2'b00);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrun_out_valid", ovld[0], 0);
    check("midrun_in_ready", irdy[0], 1);
    check("midrun_result", {res[0], cy[0], zr[0], vf[0]}, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (ovld[0]) seen++;
      @(posedge clk); #1;
    end
    check("midrun_no_result", seen, 0);
    for (int d = 0; d < 3; d++) begin
      n_acc = 0;
      ivld[d] = 1'b1;
      a[d] = 8'h21;
      b[d] = 8'h43;
      op[d] = 2'b00;
      for (int c = 0; c < 40 && n_acc < 2; c++) begin
        if (irdy[d]) begin
          acc[n_acc] = c;
          n_acc++;
        end
        @(posedge clk); #1;
      end
      ivld[d] = 1'b0;
      check("issue_count", n_acc, 2);
      if (n_acc == 2) check("issue_interval", acc[1] - acc[0], nd(d) + 2);
      repeat (12) @(posedge clk);
      #1;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
